// File: rtl/decode_stage.sv
// decode_stage: instruction decode stage of a five-stage RV pipeline.
//
// Decodes the IF/ID instruction into control bits and a sign-extended
// immediate, reads two operands from the architectural register file
// (with write-through bypass from writeback), detects load-use hazards
// against the instruction in EX, and registers the result into ID/EX.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   if_valid              IF/ID holds a valid instruction
//   instruction, pc       IF/ID contents
//   flush                 kill the instruction currently in decode
//   wb_reg_write/rd/data  writeback request into the register file
//   stall                 to IF: hold PC and IF/ID this cycle (combinational)
//   ex_*                  ID/EX register (all registered)
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            ex_alu_src,
  output logic [3:0]      ex_alu_ctl
);

  // Register-file index width: only the low bits address storage, the
  // top bit (NREGS=16) marks an out-of-range register.
  localparam int AW = (NREGS > 16) ? 5 : 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [3:0] alu_ctl;
  } ctl_t;

  // funct3/funct7 to ALU operation. SUB only exists for register-register
  // ops; for OP-IMM funct7[5] only selects arithmetic right shift.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5,
                                        input logic is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Main control decode; unknown opcodes decode to all-zero controls.
  function automatic ctl_t decode_ctl(input logic [31:0] ins);
    ctl_t c;
    c = '0;
    case (ins[6:0])
      OP_REG:    begin c.reg_write = 1'b1;
                       c.alu_ctl = alu_op(ins[14:12], ins[30], 1'b1); end
      OP_IMM:    begin c.reg_write = 1'b1; c.alu_src = 1'b1;
                       c.alu_ctl = alu_op(ins[14:12], ins[30], 1'b0); end
      OP_LOAD:   begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
                       c.alu_src = 1'b1; c.alu_ctl = ALU_ADD; end
      OP_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_ctl = ALU_ADD; end
      OP_BRANCH: begin c.branch = 1'b1; c.alu_ctl = ALU_SUB; end
      OP_LUI:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_ctl = ALU_PASSB; end
      OP_AUIPC:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_ctl = ALU_ADD; end
      OP_JAL:    begin c.reg_write = 1'b1; c.branch = 1'b1; c.alu_ctl = ALU_ADD; end
      OP_JALR:   begin c.reg_write = 1'b1; c.branch = 1'b1; c.alu_src = 1'b1;
                       c.alu_ctl = ALU_ADD; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Immediate assembly at 32 bits; sign extension to XLEN happens after.
  function automatic logic signed [31:0] imm_gen(input logic [31:0] ins);
    logic signed [31:0] v;
    case (ins[6:0])
      OP_LOAD, OP_IMM, OP_JALR: v = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                 v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:                v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                                     ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         v = {ins[31:12], 12'b0};
      OP_JAL:                   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                                     ins[30:21], 1'b0};
      default:                  v = '0;
    endcase
    return v;
  endfunction

  function automatic logic signed [XLEN-1:0] sext_imm(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic in_range(input logic [4:0] r);
    return (NREGS == 32) || !r[4];
  endfunction

  // Operand select: out-of-range and x0 read as zero, then writeback bypass,
  // then stored value.
  function automatic logic [XLEN-1:0] rf_sel(input logic [4:0] r,
                                             input logic [XLEN-1:0] stored,
                                             input logic we, input logic [4:0] wrd,
                                             input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] v;
    if (r == 5'd0 || !in_range(r))  v = '0;
    else if (we && wrd == r)        v = wdata;
    else                            v = stored;
    return v;
  endfunction

  logic [XLEN-1:0] regs [NREGS];

  ctl_t                   ctl_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [4:0]             rs1_p0, rs2_p0, rd_p0;
  logic [XLEN-1:0]        rs1_data_p0, rs2_data_p0;
  logic                   use_rs1_p0, use_rs2_p0;
  logic                   hazard_p0;
  logic                   vld_p0;

  // ---- ID: decode, operand read, hazard detection ----
  assign ctl_p0 = decode_ctl(instruction);
  assign imm_p0 = sext_imm(imm_gen(instruction));
  assign rd_p0  = instruction[11:7];
  assign rs1_p0 = instruction[19:15];
  assign rs2_p0 = instruction[24:20];

  assign rs1_data_p0 = rf_sel(rs1_p0, regs[rs1_p0[AW-1:0]], wb_reg_write, wb_rd, wb_data);
  assign rs2_data_p0 = rf_sel(rs2_p0, regs[rs2_p0[AW-1:0]], wb_reg_write, wb_rd, wb_data);

  assign use_rs1_p0 = !(instruction[6:0] == OP_LUI || instruction[6:0] == OP_AUIPC ||
                        instruction[6:0] == OP_JAL);
  assign use_rs2_p0 = (instruction[6:0] == OP_REG || instruction[6:0] == OP_STORE ||
                       instruction[6:0] == OP_BRANCH);

  assign hazard_p0 = if_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                     ((use_rs1_p0 && ex_rd == rs1_p0) || (use_rs2_p0 && ex_rd == rs2_p0));

  // Flush kills the instruction outright, so it never needs to be held.
  assign stall  = hazard_p0 && !flush && !reset;
  assign vld_p0 = if_valid && !flush && !stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_reg_write && wb_rd != 5'd0 && in_range(wb_rd)) begin
      regs[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  // ---- ID/EX register ----
  always_ff @(posedge clock) begin
    if (reset || !vld_p0) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_ctl    <= '0;
    end else begin
      ex_valid      <= 1'b1;
      ex_pc         <= pc;
      ex_rs1_data   <= rs1_data_p0;
      ex_rs2_data   <= rs2_data_p0;
      ex_imm        <= imm_p0;
      ex_rs1        <= rs1_p0;
      ex_rs2        <= rs2_p0;
      ex_rd         <= rd_p0;
      ex_reg_write  <= ctl_p0.reg_write;
      ex_mem_read   <= ctl_p0.mem_read;
      ex_mem_write  <= ctl_p0.mem_write;
      ex_mem_to_reg <= ctl_p0.mem_to_reg;
      ex_branch     <= ctl_p0.branch;
      ex_alu_src    <= ctl_p0.alu_src;
      ex_alu_ctl    <= ctl_p0.alu_ctl;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  ctl;   // {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src}
    logic [3:0]  alu;
  } exp_t;

  localparam logic [31:0] I_ADD_7_5_6   = 32'h006283B3;
  localparam logic [31:0] I_LD_5        = 32'h0080B283;  // ld x5,8(x1)
  localparam logic [31:0] I_ADD_6_5_1   = 32'h00128333;
  localparam logic [31:0] I_LUI_5       = 32'h000282B7;  // lui x5,0x28 (rs1 field = 5)
  localparam logic [31:0] I_ADD_10_9_0  = 32'h00048533;
  localparam logic [31:0] I_ADDI_12_9   = 32'hFFF48613;  // addi x12,x9,-1
  localparam logic [31:0] I_ADD_11_0_0  = 32'h000005B3;
  localparam logic [31:0] I_SD_6        = 32'hFE60BC23;  // sd x6,-8(x1)
  localparam logic [31:0] I_SD_5        = 32'hFE50BC23;  // sd x5,-8(x1)
  localparam logic [31:0] I_ADD_13_20_0 = 32'h000A06B3;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] PASSB = 4'b1010;
  localparam logic [5:0] C_R = 6'b100000, C_LD = 6'b110101, C_I = 6'b100001, C_S = 6'b001001;
  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic [63:0] pc = '0;
  logic        flush = 1'b0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;

  logic        stall32, v32, rw32, mr32, mw32, m2r32, br32, as32;
  logic [63:0] pc32, r1d32, r2d32, imm32;
  logic [4:0]  r1_32, r2_32, rd32;
  logic [3:0]  alu32;
  logic        stall16, v16, rw16, mr16, mw16, m2r16, br16, as16;
  logic [63:0] pc16, r1d16, r2d16, imm16;
  logic [4:0]  r1_16, r2_16, rd16;
  logic [3:0]  alu16;

  decode_stage #(.XLEN(64), .NREGS(32)) dut32 (
    .clock(clock), .reset(reset), .if_valid(if_valid), .instruction(instruction), .pc(pc),
    .flush(flush), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall32), .ex_valid(v32), .ex_pc(pc32), .ex_rs1_data(r1d32), .ex_rs2_data(r2d32),
    .ex_imm(imm32), .ex_rs1(r1_32), .ex_rs2(r2_32), .ex_rd(rd32), .ex_reg_write(rw32),
    .ex_mem_read(mr32), .ex_mem_write(mw32), .ex_mem_to_reg(m2r32), .ex_branch(br32),
    .ex_alu_src(as32), .ex_alu_ctl(alu32));

  decode_stage #(.XLEN(64), .NREGS(16)) dut16 (
    .clock(clock), .reset(reset), .if_valid(if_valid), .instruction(instruction), .pc(pc),
    .flush(flush), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall16), .ex_valid(v16), .ex_pc(pc16), .ex_rs1_data(r1d16), .ex_rs2_data(r2d16),
    .ex_imm(imm16), .ex_rs1(r1_16), .ex_rs2(r2_16), .ex_rd(rd16), .ex_reg_write(rw16),
    .ex_mem_read(mr16), .ex_mem_write(mw16), .ex_mem_to_reg(m2r16), .ex_branch(br16),
    .ex_alu_src(as16), .ex_alu_ctl(alu16));

  exp_t act32, act16;
  assign act32 = {v32, pc32, r1d32, r2d32, imm32, r1_32, r2_32, rd32,
                  {rw32, mr32, mw32, m2r32, br32, as32}, alu32};
  assign act16 = {v16, pc16, r1d16, r2d16, imm16, r1_16, r2_16, rd16,
                  {rw16, mr16, mw16, m2r16, br16, as16}, alu16};

  always #5 clock = ~clock;

  exp_t q32[$];
  exp_t q16[$];
  int   qtag[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  localparam exp_t Z = '0;

  function automatic exp_t mk(input logic [63:0] p, input logic [63:0] d1, input logic [63:0] d2,
                              input logic [63:0] im, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [5:0] c, input logic [3:0] a);
    exp_t e;
    e.valid = 1'b1; e.pc = p; e.rs1d = d1; e.rs2d = d2; e.imm = im;
    e.rs1 = s1; e.rs2 = s2; e.rd = d; e.ctl = c; e.alu = a;
    return e;
  endfunction

  // Drive one decode-cycle's inputs on the falling edge, queue what the
  // ID/EX register must hold after the next rising edge, check stall.
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] p,
                      input bit fl, input bit we, input logic [4:0] wrd, input logic [63:0] wd,
                      input bit rst, input bit exp_stall, input exp_t e32, input exp_t e16);
    @(negedge clock);
    step_no++;
    reset = rst; if_valid = v; instruction = ins; pc = p; flush = fl;
    wb_reg_write = we; wb_rd = wrd; wb_data = wd;
    q32.push_back(e32);
    q16.push_back(e16);
    qtag.push_back(step_no);
    #1;
    checks++;
    if (stall32 !== exp_stall) begin
      errors++;
      $display("FAIL stall32 step %0d: got %b, expected %b", step_no, stall32, exp_stall);
    end
    checks++;
    if (stall16 !== exp_stall) begin
      errors++;
      $display("FAIL stall16 step %0d: got %b, expected %b", step_no, stall16, exp_stall);
    end
  endtask

  // Monitor: the ID/EX register presents a new value every rising edge.
  initial begin
    exp_t e;
    int   t;
    forever begin
      @(posedge clock);
      #1;
      if (q32.size() > 0 && q16.size() > 0 && qtag.size() > 0) begin
        t = qtag.pop_front();
        e = q32.pop_front();
        checks++;
        if (act32 !== e) begin
          errors++;
          $display("FAIL idex32 step %0d: got %h, expected %h", t, act32, e);
        end
        e = q16.pop_front();
        checks++;
        if (act16 !== e) begin
          errors++;
          $display("FAIL idex16 step %0d: got %h, expected %h", t, act16, e);
        end
      end
    end
  end

  initial begin
    exp_t ld, e;
    // reset, including a valid instruction presented during reset
    step(0, '0, '0, 0, 0, 0, 0, 1, 0, Z, Z);
    step(1, I_ADD_7_5_6, 64'h100, 0, 1, 5, 64'h99, 1, 0, Z, Z);
    // writebacks with nothing to decode
    step(0, '0, '0, 0, 1, 5, 64'h1234, 0, 0, Z, Z);
    step(0, '0, '0, 0, 1, 6, 64'h1, 0, 0, Z, Z);
    step(0, '0, '0, 0, 1, 1, 64'h10, 0, 0, Z, Z);
    // ADD x7,x5,x6
    e = mk(64'h100, 64'h1234, 64'h1, 0, 5, 6, 7, C_R, ADD);
    step(1, I_ADD_7_5_6, 64'h100, 0, 0, 0, 0, 0, 0, e, e);
    // LD x5 then dependent ADD: one-cycle stall, then issue
    ld = mk(64'h104, 64'h10, 64'h0, 64'h8, 1, 8, 5, C_LD, ADD);
    step(1, I_LD_5, 64'h104, 0, 0, 0, 0, 0, 0, ld, ld);
    step(1, I_ADD_6_5_1, 64'h108, 0, 0, 0, 0, 0, 1, Z, Z);
    e = mk(64'h108, 64'h1234, 64'h10, 0, 5, 1, 6, C_R, ADD);
    step(1, I_ADD_6_5_1, 64'h108, 0, 0, 0, 0, 0, 0, e, e);
    // LD x5 then LUI x5 (rs1 field = 5 but unused): no stall
    ld.pc = 64'h10C;
    step(1, I_LD_5, 64'h10C, 0, 0, 0, 0, 0, 0, ld, ld);
    e = mk(64'h110, 64'h1234, 64'h0, 64'h28000, 5, 0, 5, C_I, PASSB);
    step(1, I_LUI_5, 64'h110, 0, 0, 0, 0, 0, 0, e, e);
    // same-cycle writeback x9 bypassed into decode
    e = mk(64'h114, 64'hAA, 64'h0, 0, 9, 0, 10, C_R, ADD);
    step(1, I_ADD_10_9_0, 64'h114, 0, 1, 9, 64'hAA, 0, 0, e, e);
    // negative I-immediate sign extension
    e = mk(64'h118, 64'hAA, 64'h0, NEG1, 9, 31, 12, C_I, ADD);
    step(1, I_ADDI_12_9, 64'h118, 0, 0, 0, 0, 0, 0, e, e);
    // writes to x0 discarded, and not bypassed
    step(0, '0, '0, 0, 1, 0, 64'hFF, 0, 0, Z, Z);
    e = mk(64'h11C, 64'h0, 64'h0, 0, 0, 0, 11, C_R, ADD);
    step(1, I_ADD_11_0_0, 64'h11C, 0, 1, 0, 64'h55, 0, 0, e, e);
    // store with negative S-immediate
    e = mk(64'h120, 64'h10, 64'h1, NEG8, 1, 6, 24, C_S, ADD);
    step(1, I_SD_6, 64'h120, 0, 0, 0, 0, 0, 0, e, e);
    // hazard through rs2 of a store
    ld.pc = 64'h124;
    step(1, I_LD_5, 64'h124, 0, 0, 0, 0, 0, 0, ld, ld);
    step(1, I_SD_5, 64'h128, 0, 0, 0, 0, 0, 1, Z, Z);
    e = mk(64'h128, 64'h10, 64'h1234, NEG8, 1, 5, 24, C_S, ADD);
    step(1, I_SD_5, 64'h128, 0, 0, 0, 0, 0, 0, e, e);
    // hazardous instruction with if_valid=0: no stall
    ld.pc = 64'h12C;
    step(1, I_LD_5, 64'h12C, 0, 0, 0, 0, 0, 0, ld, ld);
    step(0, I_ADD_6_5_1, 64'h130, 0, 0, 0, 0, 0, 0, Z, Z);
    // flush beats a present hazard
    step(1, I_LD_5, 64'h12C, 0, 0, 0, 0, 0, 0, ld, ld);
    step(1, I_ADD_6_5_1, 64'h130, 1, 0, 0, 0, 0, 0, Z, Z);
    // out-of-range register x20 on the 16-register instance
    step(0, '0, '0, 0, 1, 20, 64'h77, 0, 0, Z, Z);
    e = mk(64'h134, 64'h77, 64'h0, 0, 20, 0, 13, C_R, ADD);
    ld = mk(64'h134, 64'h0, 64'h0, 0, 20, 0, 13, C_R, ADD);
    step(1, I_ADD_13_20_0, 64'h134, 0, 0, 0, 0, 0, 0, e, ld);
    // reset during a load-use stall drops the stalled instruction
    ld = mk(64'h138, 64'h10, 64'h0, 64'h8, 1, 8, 5, C_LD, ADD);
    step(1, I_LD_5, 64'h138, 0, 0, 0, 0, 0, 0, ld, ld);
    step(1, I_ADD_6_5_1, 64'h13C, 0, 1, 3, 64'h33, 1, 0, Z, Z);
    // after reset every register reads 0
    e = mk(64'h140, 64'h0, 64'h0, 0, 5, 6, 7, C_R, ADD);
    step(1, I_ADD_7_5_6, 64'h140, 0, 0, 0, 0, 0, 0, e, e);
    e = mk(64'h144, 64'h0, 64'h0, 0, 20, 0, 13, C_R, ADD);
    step(1, I_ADD_13_20_0, 64'h144, 0, 0, 0, 0, 0, 0, e, e);
    @(negedge clock);
    if_valid = 1'b0; wb_reg_write = 1'b0;
    for (int i = 0; i < 10 && (q32.size() > 0 || q16.size() > 0); i++) @(negedge clock);
    checks++;
    if (q32.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, expected 0", q32.size() + q16.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/register width.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; legal values are 16 or 32.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port if_valid  in  1  IF/ID register holds a valid instruction.
REQ-006 SHALL have ports instruction  in  32 and pc  in  XLEN, carrying the IF/ID contents.
REQ-007 SHALL have port flush  in  1  taken-branch kill of the instruction currently in decode.
REQ-008 SHALL have ports wb_reg_write  in  1, wb_rd  in  5 and wb_data  in  XLEN, carrying the writeback request.
REQ-009 SHALL have port stall  out  1  to IF: hold PC and IF/ID this cycle.
REQ-010 SHALL have registered outputs ex_valid 1, ex_pc XLEN, ex_rs1_data XLEN, ex_rs2_data XLEN, ex_imm XLEN, ex_rs1 5, ex_rs2 5 and ex_rd 5, forming the ID/EX register.
REQ-011 SHALL have registered control outputs ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch and ex_alu_src, each 1 bit, plus ex_alu_ctl 4 bits.

Function
REQ-012 SHALL decode control and immediate with the existing control_unit and immediate_generator, with the immediate sign-extended to XLEN.
REQ-013 SHALL contain an NREGS x XLEN register file in which x0 always reads 0 and writes to it are discarded.
REQ-014 SHALL write wb_data to register wb_rd at the clock edge when wb_reg_write=1, wb_rd!=0, wb_rd<NREGS and reset=0.
REQ-015 SHALL read both register ports combinationally, with write-through bypass: a read of register r returns wb_data when wb_reg_write=1, wb_rd==r and r!=0.
REQ-016 SHALL return 0 for any register read at an index >= NREGS, and SHALL ignore writes to such an index.
REQ-017 SHALL treat rs1 as used for all opcodes except LUI 0110111, AUIPC 0010111 and JAL 1101111.
REQ-018 SHALL treat rs2 as used only for opcodes 0110011, 0100011 and 1100011.
REQ-019 SHALL detect a load-use hazard when if_valid=1, ex_valid=1, ex_mem_read=1, ex_rd!=0, and ex_rd equals a used rs1 or a used rs2.
REQ-020 SHALL drive stall=1, combinationally, exactly when a load-use hazard is detected and flush=0; otherwise stall=0.
REQ-021 SHALL load the ID/EX register with the decoded instruction, with ex_valid=1, one cycle after acceptance when if_valid=1, flush=0 and stall=0.
REQ-022 SHALL load a bubble when if_valid=0, or flush=1, or stall=1; a bubble sets every ID/EX output to 0.
REQ-023 SHALL give flush priority over stall: a simultaneous hazard and flush produces a bubble with stall=0.
REQ-024 SHALL resolve a stalled instruction in the next cycle, because the bubble clears ex_mem_read; a load-use stall therefore lasts exactly one cycle.
REQ-025 SHALL perform the register file write and an ID/EX capture in the same cycle without conflict; the bypass supplies the new value to the captured data.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, clear every ID/EX output to 0 and every register-file entry to 0.
REQ-027 SHALL hold stall=0 while reset=1.
REQ-028 SHALL give reset priority over flush, stall and writeback; reset asserted mid-stall drops the stalled instruction.

Verification
REQ-029 SHALL pass this scenario: write x5=0x1234 via WB, then decode ADD x7,x5,x6 with x6=1 -> next cycle ex_rs1_data=0x1234, ex_rs2_data=1, ex_rd=7, ex_reg_write=1, ex_valid=1.
REQ-030 SHALL pass this scenario: LD x5 accepted, then ADD x6,x5,x1 presented -> stall=1 for one cycle, bubble in EX (ex_valid=0), and ADD issued the following cycle.
REQ-031 SHALL pass this scenario: LD x5 in EX with LUI x5 in decode -> stall=0, because LUI does not use rs1/rs2.
REQ-032 SHALL pass this scenario: WB writes x9=0xAA in the same cycle decode reads x9 -> ex_rs1_data=0xAA; a WB to x0 followed by a read of x0 -> 0.
REQ-033 SHALL pass this scenario: flush=1 while a load-use hazard is present -> stall=0, next-cycle ex_valid=0, all controls 0.
REQ-034 SHALL pass this scenario: NREGS=16, WB to x20 and then read x20 -> 0; reset mid-stream -> all ex_* outputs 0 next cycle and a read of any register returns 0.
